// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, access-type
// constants, requester identifiers and a small grant-decoding helper.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // RAM access_type values
  localparam logic ACCESS_PLAYER = 1'b0;
  localparam logic ACCESS_CHAIN  = 1'b1;

  // Requester identifiers (0 = transaction unit, 1 = block/hash unit)
  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  // Convert a one-hot two-bit grant into the winning requester index.
  function automatic logic winner_idx(input logic [1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a sole requester always wins; when both
// request, the one that was not served last wins. Purely combinational.
module rr_pick2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // Select the winner from the request vector and the last-served pointer.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == REQ_1) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between two requesters. Each access takes
// three cycles (IDLE sample, ACCESS, DONE). The winner's command is latched
// in IDLE so requester inputs may change freely once the access is in flight.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              sel0,
  input  logic              sel1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_access_type,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_result
);

  state_e              state_q,     state_d;
  logic                cmd_id_q,    cmd_id_d;
  logic                cmd_we_q,    cmd_we_d;
  logic                cmd_sel_q,   cmd_sel_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                last_q,      last_d;
  logic                gnt0_q,      gnt0_d;
  logic                gnt1_q,      gnt1_d;
  logic                done0_q,     done0_d;
  logic                done1_q,     done1_d;
  logic                wren_q,      wren_d;
  logic [DATA_W-1:0]   rdata0_q,    rdata0_d;
  logic [DATA_W-1:0]   rdata1_q,    rdata1_d;
  logic [1:0]          pick;

  rr_pick2 u_pick (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_wdata_d = cmd_wdata_q;
    last_d      = last_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    wren_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          state_d  = ST_ACCESS;
          cmd_id_d = winner_idx(pick);
          if (winner_idx(pick) == REQ_1) begin
            cmd_we_d    = we1;
            cmd_sel_d   = sel1;
            cmd_wdata_d = wdata1;
          end else begin
            cmd_we_d    = we0;
            cmd_sel_d   = sel0;
            cmd_wdata_d = wdata0;
          end
          // wren is registered so it is high for exactly the ACCESS cycle
          wren_d = (winner_idx(pick) == REQ_1) ? we1 : we0;
          gnt0_d = pick[0];
          gnt1_d = pick[1];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        done0_d = (cmd_id_q == REQ_0);
        done1_d = (cmd_id_q == REQ_1);
        if (!cmd_we_q) begin
          if (cmd_id_q == REQ_1) begin
            rdata1_d = ram_result;
          end else begin
            rdata0_d = ram_result;
          end
        end else begin
          rdata0_d = rdata0_q;
          rdata1_d = rdata1_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = cmd_id_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears wren asynchronously so an
  // in-flight write is never committed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_id_q    <= REQ_0;
      cmd_we_q    <= 1'b0;
      cmd_sel_q   <= ACCESS_PLAYER;
      cmd_wdata_q <= {DATA_W{1'b0}};
      last_q      <= REQ_1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      wren_q      <= 1'b0;
      rdata0_q    <= {DATA_W{1'b0}};
      rdata1_q    <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_wdata_q <= cmd_wdata_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      wren_q      <= wren_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign gnt0            = gnt0_q;
  assign gnt1            = gnt1_q;
  assign done0           = done0_q;
  assign done1           = done1_q;
  assign rdata0          = rdata0_q;
  assign rdata1          = rdata1_q;
  assign ram_wren        = wren_q;
  assign ram_access_type = cmd_sel_q;
  assign ram_data_in     = cmd_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and a
// transaction-level reference model.
module tb_ram_arbiter;

  localparam int DW = 48;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic          sel0 = 1'b0, sel1 = 1'b0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, ram_access_type, ram_wren;
  logic [DW-1:0] rdata0, rdata1, ram_data_in, ram_result;

  ram_arbiter #(.DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .sel0(sel0), .sel1(sel1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_access_type(ram_access_type), .ram_wren(ram_wren),
    .ram_data_in(ram_data_in), .ram_result(ram_result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: player store is full width, chain store keeps [7:0].
  logic [DW-1:0] player_mem = '0;
  logic [7:0]    chain_mem  = 8'h00;
  always @(posedge clock) begin
    if (ram_wren) begin
      if (ram_access_type) chain_mem <= ram_data_in[7:0];
      else                 player_mem <= ram_data_in;
    end
  end
  assign ram_result = ram_access_type ? {40'd0, chain_mem} : player_mem;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: transaction-level RAM contents, per-requester rdata,
  // last-served requester, and a queue of expected completions.
  typedef struct { bit id; logic [DW-1:0] rdata; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] m_player = '0;
  logic [7:0]    m_chain  = 8'h00;
  logic [DW-1:0] m_rdata [2];
  bit            m_last = 1'b1;

  function automatic void model_access(bit id, bit we, bit sel, logic [DW-1:0] wd);
    exp_t e;
    if (we) begin
      if (sel) m_chain = wd[7:0];
      else     m_player = wd;
    end else begin
      m_rdata[id] = sel ? {40'd0, m_chain} : m_player;
    end
    e.id = id;
    e.rdata = m_rdata[id];
    sb.push_back(e);
    m_last = id;
  endfunction

  function automatic void model_reset();
    m_last = 1'b1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    sb.delete();
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[DW-1:0];
  endfunction

  // Monitor: pops expectations on each done pulse and checks exclusivity.
  always @(negedge clock) begin
    exp_t e;
    bit   did;
    if (!reset) begin
      if (gnt0 || gnt1) check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
      if (done0 || done1) begin
        check("done_exclusive", 64'(done0 & done1), 64'd0);
        did = done1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: requester %0d done with nothing outstanding", did);
        end else begin
          e = sb.pop_front();
          check("done_id", 64'(did), 64'(e.id));
          check(did ? "rdata1" : "rdata0", did ? rdata1 : rdata0, e.rdata);
        end
      end
    end
  end

  // One arbitration round: raise the requests in mask, follow each to done.
  task automatic do_round(input bit [1:0] mask,
                          input bit w0, input bit s0, input logic [DW-1:0] d0,
                          input bit w1, input bit s1, input logic [DW-1:0] d1);
    bit            wv[2], sv[2], pend[2], seen[2], g, d;
    logic [DW-1:0] dv[2];
    int            lat[2];
    int            wcnt, start, nwr, first, second;
    @(negedge clock);
    wv[0] = w0; sv[0] = s0; dv[0] = d0;
    wv[1] = w1; sv[1] = s1; dv[1] = d1;
    we0 = w0; sel0 = s0; wdata0 = d0;
    we1 = w1; sel1 = s1; wdata1 = d1;
    req0 = mask[0]; req1 = mask[1];
    first  = (mask == 2'b11) ? int'(!m_last) : int'(mask[1]);
    second = 1 - first;
    model_access(first[0], wv[first], sv[first], dv[first]);
    if (mask == 2'b11) model_access(second[0], wv[second], sv[second], dv[second]);
    nwr   = int'(mask[0] && w0) + int'(mask[1] && w1);
    start = cyc;
    pend[0] = mask[0]; pend[1] = mask[1];
    seen[0] = 1'b0;    seen[1] = 1'b0;
    lat[0] = 0; lat[1] = 0;
    wcnt = 0;
    for (int t = 0; t < 20 && (pend[0] || pend[1]); t++) begin
      @(negedge clock);
      if (ram_wren) wcnt++;
      for (int i = 0; i < 2; i++) begin
        g = (i == 1) ? gnt1 : gnt0;
        d = (i == 1) ? done1 : done0;
        if (g && !seen[i]) begin
          seen[i] = 1'b1;
          check("cmd_data", ram_data_in, dv[i]);
          check("cmd_wren", 64'(ram_wren), 64'(wv[i]));
          check("cmd_sel", 64'(ram_access_type), 64'(sv[i]));
          // disturb the in-flight requester's inputs
          if (i == 1) begin wdata1 = wdata1 + 1'b1; we1 = ~we1; sel1 = ~sel1; end
          else        begin wdata0 = wdata0 + 1'b1; we0 = ~we0; sel0 = ~sel0; end
        end
        if (d && pend[i]) begin
          pend[i] = 1'b0;
          lat[i] = cyc - start;
          if (i == 1) req1 = 1'b0; else req0 = 1'b0;
        end
      end
    end
    if (pend[0] || pend[1]) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: mask=%b pending=%b%b", mask, pend[1], pend[0]);
      req0 = 1'b0; req1 = 1'b0;
    end else begin
      check("wren_cycles", 64'(wcnt), 64'(nwr));
      check("latency_first", 64'(lat[first]), 64'd2);
      if (mask == 2'b11) check("latency_second", 64'(lat[second]), 64'd5);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ndone, prev, fst;
    bit [1:0] mask;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    repeat (3) @(negedge clock);
    check("rst_gnt",   64'({gnt1, gnt0}), 64'd0);
    check("rst_done",  64'({done1, done0}), 64'd0);
    check("rst_rdata0", rdata0, 64'd0);
    check("rst_rdata1", rdata1, 64'd0);
    check("rst_wren",  64'(ram_wren), 64'd0);
    check("rst_type",  64'(ram_access_type), 64'd0);
    check("rst_din",   ram_data_in, 64'd0);
    reset = 1'b0;

    // Single-requester write/read, player and chain
    do_round(2'b01, 1'b1, 1'b0, 48'h0000_00AB_CDEF, 1'b0, 1'b0, '0);
    do_round(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    do_round(2'b10, 1'b0, 1'b0, '0, 1'b1, 1'b1, 48'h1234_5678_9A5C);
    do_round(2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);

    // Simultaneous requests, twice: order must alternate
    do_round(2'b11, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    do_round(2'b11, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);

    // Both requests held continuously: strict alternation, 3 cycles apart
    @(negedge clock);
    we0 = 1'b0; sel0 = 1'b0; we1 = 1'b0; sel1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fst = int'(!m_last);
      model_access(fst[0], 1'b0, 1'b0, '0);
    end
    ndone = 0;
    prev = -1;
    for (int t = 0; t < 40 && ndone < 6; t++) begin
      @(negedge clock);
      if (done0 || done1) begin
        if (prev >= 0) check("b2b_spacing", 64'(cyc - prev), 64'd3);
        prev = cyc;
        ndone++;
        if (ndone == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    if (ndone < 6) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout: saw %0d of 6 completions", ndone);
      req0 = 1'b0; req1 = 1'b0;
    end

    // Write data changed in flight: 1 must be written, not 2
    do_round(2'b01, 1'b1, 1'b0, 48'h1, 1'b0, 1'b0, '0);
    do_round(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      mask = 2'($urandom_range(1, 3));
      do_round(mask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_data(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_data());
    end

    // Reset during a write's ACCESS cycle
    @(negedge clock);
    we0 = 1'b1; sel0 = 1'b0; wdata0 = 48'hFFFF_FFFF_FFFF; req0 = 1'b1;
    for (int t = 0; t < 10 && !gnt0; t++) @(negedge clock);
    if (!gnt0) begin
      checks++;
      errors++;
      $display("FAIL abort_grant: gnt0 never rose");
    end
    reset = 1'b1;
    #1;
    check("abort_wren", 64'(ram_wren), 64'd0);
    check("abort_gnt",  64'({gnt1, gnt0}), 64'd0);
    check("abort_done", 64'({done1, done0}), 64'd0);
    check("abort_rdata0", rdata0, 64'd0);
    check("abort_rdata1", rdata1, 64'd0);
    model_reset();
    req0 = 1'b0; we0 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_round(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    do_round(2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);

    repeat (3) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
